// File: rtl/load_buffer.sv
`default_nettype none
// ============================================================================
// Module   : load_buffer
// Purpose  : In-order load queue; waits for base operands on the CDB, forms
//            base+imm and issues one load at a time to the load unit.
//            Define LOAD_BUF_BYPASS_EN to capture a same-cycle CDB broadcast
//            into an allocating entry.
// Revision : 1.0
// ============================================================================
module load_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic [2:0]               alloc_type,
  input  logic [5:0]               alloc_robNum,
  input  logic                     alloc_base_ready,
  input  logic [31:0]              alloc_base_val,
  input  logic [5:0]               alloc_base_tag,
  input  logic [31:0]              alloc_imm,
  input  logic                     cdb_enable,
  input  logic [5:0]               cdb_robNum,
  input  logic [31:0]              cdb_data,
  input  logic                     lu_busy,
  input  logic                     flush,
  output logic                     loadEnable,
  output logic [2:0]               loadType,
  output logic [31:0]              addr,
  output logic [5:0]               robNum,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   c_depth   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);

  logic        r_valid  [DEPTH];
  logic [2:0]  r_type   [DEPTH];
  logic [5:0]  r_rob    [DEPTH];
  logic        r_bready [DEPTH];
  logic [31:0] r_bval   [DEPTH];
  logic [5:0]  r_btag   [DEPTH];
  logic [31:0] r_imm    [DEPTH];

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic             r_load_en;
  logic [2:0]       r_load_type;
  logic [31:0]      r_addr;
  logic [5:0]       r_rob_out;

  logic w_alloc;
  logic w_issue;
  logic w_byp;

  assign alloc_ready = (r_count < c_depth);
  assign w_alloc     = alloc_valid && alloc_ready;
  // The low-cycle requirement between pulses comes from gating on r_load_en.
  assign w_issue     = r_valid[r_head] && r_bready[r_head] && !lu_busy && !r_load_en;

`ifdef LOAD_BUF_BYPASS_EN
  assign w_byp = cdb_enable && !alloc_base_ready && (alloc_base_tag == cdb_robNum);
`else
  assign w_byp = 1'b0;
`endif

  assign loadEnable = r_load_en;
  assign loadType   = r_load_type;
  assign addr       = r_addr;
  assign robNum     = r_rob_out;
  assign count      = r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i]  <= 1'b0;
        r_type[i]   <= 3'd0;
        r_rob[i]    <= 6'd0;
        r_bready[i] <= 1'b0;
        r_bval[i]   <= 32'd0;
        r_btag[i]   <= 6'd0;
        r_imm[i]    <= 32'd0;
      end
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_load_en   <= 1'b0;
      r_load_type <= 3'd0;
      r_addr      <= 32'd0;
      r_rob_out   <= 6'd0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
      end
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_load_en <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_valid[i] && !r_bready[i] && cdb_enable && (r_btag[i] == cdb_robNum)) begin
          r_bready[i] <= 1'b1;
          r_bval[i]   <= cdb_data;
        end
      end

      // The tail slot is never valid while not full, so it cannot also be snooped.
      if (w_alloc) begin
        r_valid[r_tail]  <= 1'b1;
        r_type[r_tail]   <= alloc_type;
        r_rob[r_tail]    <= alloc_robNum;
        r_bready[r_tail] <= alloc_base_ready | w_byp;
        r_bval[r_tail]   <= w_byp ? cdb_data : alloc_base_val;
        r_btag[r_tail]   <= alloc_base_tag;
        r_imm[r_tail]    <= alloc_imm;
        r_tail           <= r_tail + c_ptr_one;
      end

      if (w_issue) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + c_ptr_one;
        r_addr          <= r_bval[r_head] + r_imm[r_head];
        r_load_type     <= r_type[r_head];
        r_rob_out       <= r_rob[r_head];
      end

      r_load_en <= w_issue;
      r_count   <= r_count + (PTR_W+1)'(w_alloc) - (PTR_W+1)'(w_issue);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_buffer
// Purpose  : Self-checking bench for load_buffer against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_load_buffer;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        alloc_valid, alloc_base_ready, cdb_enable, lu_busy, flush;
  logic [2:0]  alloc_type;
  logic [5:0]  alloc_robNum, alloc_base_tag, cdb_robNum;
  logic [31:0] alloc_base_val, alloc_imm, cdb_data;
  logic        alloc_ready, loadEnable;
  logic [2:0]  loadType;
  logic [31:0] addr;
  logic [5:0]  robNum;
  logic [2:0]  count;

  always #5 clock = ~clock;

  load_buffer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_type(alloc_type),
    .alloc_robNum(alloc_robNum), .alloc_base_ready(alloc_base_ready),
    .alloc_base_val(alloc_base_val), .alloc_base_tag(alloc_base_tag), .alloc_imm(alloc_imm),
    .cdb_enable(cdb_enable), .cdb_robNum(cdb_robNum), .cdb_data(cdb_data),
    .lu_busy(lu_busy), .flush(flush),
    .loadEnable(loadEnable), .loadType(loadType), .addr(addr), .robNum(robNum), .count(count)
  );

  typedef struct {
    logic [2:0]  typ;
    logic [5:0]  rob;
    logic        rdy;
    logic [31:0] base;
    logic [5:0]  tag;
    logic [31:0] imm;
  } ent_t;

  ent_t        mq[$];
  logic        m_le = 1'b0;
  logic [31:0] m_addr = 32'd0;
  logic [2:0]  m_type = 3'd0;
  logic [5:0]  m_rob = 6'd0;
  int          total = 0;
  int          bad = 0;

  function automatic logic [45:0] exp_vec();
    return {m_le, 3'(mq.size()), 1'(mq.size() < DEPTH), m_addr, m_type, m_rob};
  endfunction

  function automatic logic [45:0] got_vec();
    return {loadEnable, count, alloc_ready, addr, loadType, robNum};
  endfunction

  task automatic drive_idle();
    alloc_valid = 0; alloc_type = 0; alloc_robNum = 0; alloc_base_ready = 0;
    alloc_base_val = 0; alloc_base_tag = 0; alloc_imm = 0;
    cdb_enable = 0; cdb_robNum = 0; cdb_data = 0; lu_busy = 0; flush = 0;
  endtask

  task automatic set_alloc(input logic [2:0] t, input logic [5:0] r, input logic rdy,
                           input logic [31:0] base, input logic [5:0] tag, input logic [31:0] imm);
    alloc_valid = 1; alloc_type = t; alloc_robNum = r; alloc_base_ready = rdy;
    alloc_base_val = base; alloc_base_tag = tag; alloc_imm = imm;
  endtask

  // Advance the reference model by one clock using the current inputs, then
  // step the DUT and land 1ns after the edge.
  task automatic tick();
    ent_t e, t;
    bit iss, alc;
    if (flush) begin
      mq.delete();
      m_le = 1'b0;
    end else begin
      iss = (mq.size() > 0) && mq[0].rdy && !lu_busy && !m_le;
      alc = alloc_valid && (mq.size() < DEPTH);
      e = '{alloc_type, alloc_robNum, alloc_base_ready, alloc_base_val, alloc_base_tag, alloc_imm};
`ifdef LOAD_BUF_BYPASS_EN
      if (!e.rdy && cdb_enable && e.tag == cdb_robNum) begin
        e.rdy = 1'b1; e.base = cdb_data;
      end
`endif
      foreach (mq[i]) begin
        t = mq[i];
        if (cdb_enable && !t.rdy && t.tag == cdb_robNum) begin
          t.rdy = 1'b1; t.base = cdb_data;
        end
        mq[i] = t;
      end
      if (iss) begin
        m_addr = mq[0].base + mq[0].imm;
        m_type = mq[0].typ;
        m_rob  = mq[0].rob;
        void'(mq.pop_front());
      end
      m_le = iss;
      if (alc) mq.push_back(e);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_le = 0; m_addr = 0; m_type = 0; m_rob = 0;
  endtask

  task automatic drain();
    drive_idle();
    flush = 1;
    tick();
    flush = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    reset_n = 0;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (got_vec() !== {1'b0, 3'd0, 1'b1, 32'd0, 3'd0, 6'd0}) begin
      bad++; $display("FAIL reset got=%h exp=%h", got_vec(), {1'b0, 3'd0, 1'b1, 32'd0, 3'd0, 6'd0});
    end
    reset_n = 1;
    model_reset();
  endtask

  task automatic test_single_lw();
    set_alloc(3'b010, 6'd5, 1'b1, 32'h100, 6'd0, 32'h8);
    tick();
    drive_idle();
    total++;
    if ({loadEnable, count} !== {1'b0, 3'd1}) begin
      bad++; $display("FAIL single_alloc got=%b/%0d exp=0/1", loadEnable, count);
    end
    tick();
    total++;
    if ({loadEnable, addr, loadType, robNum, count} !== {1'b1, 32'h108, 3'b010, 6'd5, 3'd0}) begin
      bad++; $display("FAIL single_issue got le=%b addr=%h type=%b rob=%0d cnt=%0d exp 1/108/010/5/0",
                      loadEnable, addr, loadType, robNum, count);
    end
    tick();
    total++;
    if ({loadEnable, addr, robNum} !== {1'b0, 32'h108, 6'd5}) begin
      bad++; $display("FAIL single_hold got le=%b addr=%h rob=%0d exp 0/108/5", loadEnable, addr, robNum);
    end
  endtask

  task automatic test_wait_operand();
    drain();
    set_alloc(3'b000, 6'd3, 1'b0, 32'd0, 6'd12, 32'hFFFF_FFFC);
    tick();
    drive_idle();
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (got_vec() !== exp_vec()) begin
        bad++; $display("FAIL wait_hold c=%0d got=%h exp=%h", c, got_vec(), exp_vec());
      end
    end
    cdb_enable = 1; cdb_robNum = 6'd12; cdb_data = 32'h2000;
    tick();
    drive_idle();
    total++;
    if (loadEnable !== 1'b0) begin
      bad++; $display("FAIL wait_early got le=%b exp=0", loadEnable);
    end
    tick();
    total++;
    if ({loadEnable, addr, loadType, robNum} !== {1'b1, 32'h1FFC, 3'b000, 6'd3}) begin
      bad++; $display("FAIL wait_issue got le=%b addr=%h type=%b rob=%0d exp 1/1ffc/000/3",
                      loadEnable, addr, loadType, robNum);
    end
  endtask

  task automatic test_ordering();
    int t0, t1, n;
    logic [11:0] seq;
    drain();
    set_alloc(3'b010, 6'd1, 1'b0, 32'd0, 6'd7, 32'h10);
    tick();
    set_alloc(3'b001, 6'd2, 1'b1, 32'h500, 6'd0, 32'h4);
    tick();
    drive_idle();
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (got_vec() !== exp_vec() || loadEnable !== 1'b0) begin
        bad++; $display("FAIL order_block c=%0d got=%h exp=%h", c, got_vec(), exp_vec());
      end
    end
    cdb_enable = 1; cdb_robNum = 6'd7; cdb_data = 32'h300;
    n = 0; seq = 0; t0 = 0; t1 = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      drive_idle();
      total++;
      if (got_vec() !== exp_vec()) begin
        bad++; $display("FAIL order_vec c=%0d got=%h exp=%h", c, got_vec(), exp_vec());
      end
      if (loadEnable) begin
        seq = {seq[5:0], robNum};
        if (n == 0) t0 = c; else t1 = c;
        n++;
      end
    end
    total++;
    if (n != 2 || seq !== {6'd1, 6'd2} || (t1 - t0) < 2) begin
      bad++; $display("FAIL order_seq got n=%0d seq=%h gap=%0d exp n=2 seq=042 gap>=2", n, seq, t1 - t0);
    end
  endtask

  task automatic test_full();
    int n, last, mingap;
    logic [23:0] seq;
    drain();
    lu_busy = 1;
    for (int i = 0; i < 4; i++) begin
      set_alloc(3'b010, 6'(20 + i), 1'b1, 32'(i * 64), 6'd0, 32'h4);
      tick();
      total++;
      if (got_vec() !== exp_vec()) begin
        bad++; $display("FAIL full_fill i=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
    end
    total++;
    if ({alloc_ready, count} !== {1'b0, 3'd4}) begin
      bad++; $display("FAIL full_ready got rdy=%b cnt=%0d exp 0/4", alloc_ready, count);
    end
    set_alloc(3'b010, 6'd24, 1'b1, 32'h999, 6'd0, 32'h0);
    tick();
    total++;
    if (count !== 3'd4) begin
      bad++; $display("FAIL full_drop got cnt=%0d exp=4", count);
    end
    drive_idle();
    n = 0; last = -10; mingap = 100; seq = 0;
    for (int c = 0; c < 14; c++) begin
      tick();
      total++;
      if (got_vec() !== exp_vec()) begin
        bad++; $display("FAIL full_drain c=%0d got=%h exp=%h", c, got_vec(), exp_vec());
      end
      if (loadEnable) begin
        if (n > 0 && c - last < mingap) mingap = c - last;
        seq = {seq[17:0], robNum};
        last = c;
        n++;
      end
    end
    total++;
    if (n != 4 || seq !== {6'd20, 6'd21, 6'd22, 6'd23} || mingap < 2 || count !== 3'd0) begin
      bad++; $display("FAIL full_seq got n=%0d seq=%h mingap=%0d cnt=%0d exp 4/20..23/>=2/0",
                      n, seq, mingap, count);
    end
  endtask

  task automatic test_flush();
    drain();
    lu_busy = 1;
    for (int i = 0; i < 3; i++) begin
      set_alloc(3'b100, 6'(30 + i), 1'b1, 32'h1000, 6'd0, 32'(i));
      tick();
    end
    set_alloc(3'b100, 6'd33, 1'b1, 32'h2000, 6'd0, 32'h0);
    flush = 1;
    tick();
    drive_idle();
    total++;
    if ({loadEnable, count, alloc_ready} !== {1'b0, 3'd0, 1'b1}) begin
      bad++; $display("FAIL flush got le=%b cnt=%0d rdy=%b exp 0/0/1", loadEnable, count, alloc_ready);
    end
    for (int c = 0; c < 14; c++) begin
      if (c < 7) set_alloc(3'b101, 6'(40 + c), 1'b1, 32'(c * 256), 6'd0, 32'h2);
      else drive_idle();
      tick();
      total++;
      if (got_vec() !== exp_vec()) begin
        bad++; $display("FAIL flush_wrap c=%0d got=%h exp=%h", c, got_vec(), exp_vec());
      end
    end
    drive_idle();
  endtask

  task automatic test_bypass();
    drain();
    set_alloc(3'b010, 6'd11, 1'b0, 32'd0, 6'd9, 32'd0);
    cdb_enable = 1; cdb_robNum = 6'd9; cdb_data = 32'h40;
    tick();
    drive_idle();
    tick();
`ifdef LOAD_BUF_BYPASS_EN
    total++;
    if ({loadEnable, addr, robNum} !== {1'b1, 32'h40, 6'd11}) begin
      bad++; $display("FAIL bypass got le=%b addr=%h rob=%0d exp 1/40/11", loadEnable, addr, robNum);
    end
`else
    total++;
    if ({loadEnable, count} !== {1'b0, 3'd1}) begin
      bad++; $display("FAIL bypass_off got le=%b cnt=%0d exp 0/1", loadEnable, count);
    end
    cdb_enable = 1; cdb_robNum = 6'd9; cdb_data = 32'h40;
    tick();
    drive_idle();
    tick();
    total++;
    if ({loadEnable, addr, robNum} !== {1'b1, 32'h40, 6'd11}) begin
      bad++; $display("FAIL bypass_late got le=%b addr=%h rob=%0d exp 1/40/11", loadEnable, addr, robNum);
    end
`endif
  endtask

  task automatic test_random();
    logic [2:0] types [5];
    types = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    drain();
    for (int c = 0; c < 600; c++) begin
      alloc_valid      = ($urandom_range(0, 2) != 0);
      alloc_type       = types[$urandom_range(0, 4)];
      alloc_robNum     = 6'($urandom);
      alloc_base_ready = $urandom_range(0, 1) == 1;
      alloc_base_val   = $urandom;
      alloc_base_tag   = 6'($urandom_range(0, 7));
      alloc_imm        = $urandom;
      cdb_enable       = $urandom_range(0, 1) == 1;
      cdb_robNum       = 6'($urandom_range(0, 7));
      cdb_data         = $urandom;
      lu_busy          = ($urandom_range(0, 3) == 0);
      flush            = ($urandom_range(0, 39) == 0);
`ifndef LOAD_BUF_BYPASS_EN
      if (alloc_valid && !alloc_base_ready && cdb_enable && alloc_base_tag == cdb_robNum)
        cdb_robNum = cdb_robNum ^ 6'h08;
`endif
      tick();
      total++;
      if (got_vec() !== exp_vec()) begin
        bad++; $display("FAIL random c=%0d got=%h exp=%h", c, got_vec(), exp_vec());
      end
      if (c == 300) begin
        reset_n = 0;
        #1;
        total++;
        if (got_vec() !== {1'b0, 3'd0, 1'b1, 32'd0, 3'd0, 6'd0}) begin
          bad++; $display("FAIL async_reset got=%h exp=%h", got_vec(), {1'b0, 3'd0, 1'b1, 32'd0, 3'd0, 6'd0});
        end
        model_reset();
        #1 reset_n = 1;
      end
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_single_lw();
    test_wait_operand();
    test_ordering();
    test_full();
    test_flush();
    test_bypass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
